// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared state encoding, field widths and timer sizing for the mole game
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        SHOW,
        DONE
    } state_t;

    localparam int BOX_W    = 3;
    localparam int DELAY_W  = 2;
    localparam int COLOUR_W = 3;

    // Sized for the longest gap (max delay code is 3, so 4 units); the show window is folded in so neither load overflows.
    function automatic int timer_w(input int gap_ticks, input int cyc_per_tick, input int show_ticks);
        int max_cnt;
        max_cnt = 4 * gap_ticks * cyc_per_tick;
        if (show_ticks * cyc_per_tick > max_cnt) begin
            max_cnt = show_ticks * cyc_per_tick;
        end
        return (max_cnt > 1) ? $clog2(max_cnt) : 1;
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// rtl/mole_scheduler_if.sv - draw request/response handshake between scheduler and LFSR register
interface mole_scheduler_if;
    import mole_pkg::*;

    logic                oRngEnb;
    logic                iRngValid;
    logic [BOX_W-1:0]    iRngBox;
    logic [DELAY_W-1:0]  iRngDelay;
    logic [COLOUR_W-1:0] iRngColour;

    modport master (
        output oRngEnb,
        input  iRngValid,
        input  iRngBox,
        input  iRngDelay,
        input  iRngColour
    );

    modport slave (
        input  oRngEnb,
        output iRngValid,
        output iRngBox,
        output iRngDelay,
        output iRngColour
    );

endinterface

// File: rtl/mole_timer.sv
// rtl/mole_timer.sv - loadable down-counter shared by the gap and show phases
module mole_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole sequencer: draw, wait, light a box, judge hits, keep score
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int NUM_BOXES    = 8,
    parameter int CYC_PER_TICK = 50000,
    parameter int GAP_TICKS    = 4,
    parameter int SHOW_TICKS   = 20,
    parameter int ROUNDS       = 16,
    parameter int SCORE_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iStart,
    input  logic [NUM_BOXES-1:0] iHit,
    mole_scheduler_if.master     rng,
    output logic [NUM_BOXES-1:0] oMoleOn,
    output logic [COLOUR_W-1:0]  oMoleColour,
    output logic [SCORE_W-1:0]   oScore,
    output logic [SCORE_W-1:0]   oMisses,
    output logic [SCORE_W-1:0]   oRound,
    output logic                 oBusy,
    output logic                 oGameOver
);

    localparam int                 TW        = timer_w(GAP_TICKS, CYC_PER_TICK, SHOW_TICKS);
    localparam logic [TW-1:0]      SHOW_LOAD = TW'(SHOW_TICKS * CYC_PER_TICK - 1);
    localparam logic [SCORE_W-1:0] SAT       = '1;

    state_t                r_state;
    logic                  r_rng_enb;
    logic [BOX_W-1:0]      r_box;
    logic [COLOUR_W-1:0]   r_colour;
    logic [NUM_BOXES-1:0]  r_mole_on;
    logic [COLOUR_W-1:0]   r_mole_colour;
    logic [SCORE_W-1:0]    r_score;
    logic [SCORE_W-1:0]    r_misses;
    logic [SCORE_W-1:0]    r_round;
    logic                  r_busy;
    logic                  r_game_over;

    logic                  w_expired;
    logic                  w_load;
    logic [TW-1:0]         w_gap_load;
    logic [TW-1:0]         w_load_val;
    logic [NUM_BOXES-1:0]  w_box_mask;
    logic                  w_correct;
    logic                  w_wrong;
    logic [1:0]            w_miss_add;
    logic [SCORE_W:0]      w_miss_sum;
    logic [SCORE_W-1:0]    w_miss_next;
    logic [SCORE_W-1:0]    w_score_next;
    logic [SCORE_W-1:0]    w_round_next;

    always_comb begin
        w_gap_load   = TW'((int'(rng.iRngDelay) + 1) * GAP_TICKS * CYC_PER_TICK - 1);
        w_load       = ((r_state == REQ) && rng.iRngValid) || ((r_state == GAP) && w_expired);
        w_load_val   = (r_state == REQ) ? w_gap_load : SHOW_LOAD;
        w_box_mask   = NUM_BOXES'(1) << r_box;
        w_correct    = iHit[r_box];
        w_wrong      = |(iHit & ~w_box_mask);
        // A correct press trumps both a stray press and the timeout landing on the same cycle.
        w_miss_add   = w_correct ? 2'd0 : ({1'b0, w_wrong} + {1'b0, w_expired});
        w_miss_sum   = {1'b0, r_misses} + (SCORE_W + 1)'(w_miss_add);
        w_miss_next  = w_miss_sum[SCORE_W] ? SAT : w_miss_sum[SCORE_W-1:0];
        w_score_next = (r_score == SAT) ? SAT : r_score + 1'b1;
        w_round_next = r_round + 1'b1;
    end

    mole_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_rng_enb     <= 1'b0;
            r_box         <= '0;
            r_colour      <= '0;
            r_mole_on     <= '0;
            r_mole_colour <= '0;
            r_score       <= '0;
            r_misses      <= '0;
            r_round       <= '0;
            r_busy        <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (iStart) begin
                        r_state     <= REQ;
                        r_rng_enb   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                        r_score     <= '0;
                        r_misses    <= '0;
                        r_round     <= '0;
                    end
                end
                REQ: begin
                    if (rng.iRngValid) begin
                        r_state   <= GAP;
                        r_rng_enb <= 1'b0;
                        r_box     <= rng.iRngBox;
                        r_colour  <= rng.iRngColour;
                    end
                end
                GAP: begin
                    if (w_expired) begin
                        r_state       <= SHOW;
                        r_mole_on     <= w_box_mask;
                        r_mole_colour <= r_colour;
                    end
                end
                SHOW: begin
                    r_misses <= w_miss_next;
                    if (w_correct || w_expired) begin
                        if (w_correct) begin
                            r_score <= w_score_next;
                        end
                        r_round       <= w_round_next;
                        r_mole_on     <= '0;
                        r_mole_colour <= '0;
                        if (w_round_next == SCORE_W'(ROUNDS)) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state   <= REQ;
                            r_rng_enb <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rng.oRngEnb = r_rng_enb;
    assign oMoleOn     = r_mole_on;
    assign oMoleColour = r_mole_colour;
    assign oScore      = r_score;
    assign oMisses     = r_misses;
    assign oRound      = r_round;
    assign oBusy       = r_busy;
    assign oGameOver   = r_game_over;

endmodule
